// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/write-back select codes, immediate formats.
// Used by id_stage and reg_file; the RF_WB_BYPASS_EN macro is consumed by those modules.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] PMA_ALU  = 2'b00;
    localparam logic [1:0] PMA_LOAD = 2'b01;
    localparam logic [1:0] PMA_PC4  = 2'b10;
    localparam logic [1:0] PMA_IMM  = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_ADD_PC = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_type_e t);
        case (t)
            IMM_I:   gen_imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   gen_imm = {i[31:12], 12'h000};
            IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: gen_imm = 32'h0;
        endcase
    endfunction

    // SUB only exists for register-register ops; bit 30 of an I-type ADDI is immediate data.
    function automatic alu_ctrl_e alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_op);
        case (f3)
            3'b000:  alu_decode = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports, one write port, x0 hard-wired to zero.
// With RF_WB_BYPASS_EN defined, reads return the same-cycle write data on an address match.
module reg_file
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wen,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);

    logic [31:0] r_regs [31:0];
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (!rst_n)
                    r_regs[gi] <= 32'h0;
                else if (i_wen && (i_waddr == 5'(gi)) && (gi != 0))
                    r_regs[gi] <= i_wdata;
            end
        end
    endgenerate

    assign w_rd1 = (i_raddr1 == 5'd0) ? 32'h0 : r_regs[i_raddr1];
    assign w_rd2 = (i_raddr2 == 5'd0) ? 32'h0 : r_regs[i_raddr2];

`ifdef RF_WB_BYPASS_EN
    assign o_rdata1 = (i_wen && (i_waddr == i_raddr1) && (i_raddr1 != 5'd0)) ? i_wdata : w_rd1;
    assign o_rdata2 = (i_wen && (i_waddr == i_raddr2) && (i_raddr2 != 5'd0)) ? i_wdata : w_rd2;
`else
    assign o_rdata1 = w_rd1;
    assign o_rdata2 = w_rd2;
`endif

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, decoder, immediate generation, register file, hazard unit.
// RF_WB_BYPASS_EN selects regfile bypass; otherwise a WB/ID register collision costs one stall cycle.
module id_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] P_NOP_INSTR = NOP_INSTR,
    parameter logic [31:0] P_RESET_PC  = RESET_PC
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_IF,
    input  logic [31:0] PC_IF,
    input  logic        flush_ID,
    input  logic        rd_wen_EX,
    input  logic [4:0]  rd_waddr_EX,
    input  logic [1:0]  PMAItoReg_EX,
    input  logic        rd_wen_WB,
    input  logic [4:0]  rd_waddr_WB,
    input  logic [31:0] rd_wdata_WB,
    output logic        stall_IF,
    output logic [31:0] instr_ID,
    output logic [31:0] PC_ID,
    output logic [31:0] imm_ID,
    output logic [31:0] rs1_rdata_ID,
    output logic [31:0] rs2_rdata_ID,
    output logic [4:0]  rs1_raddr_ID,
    output logic [4:0]  rs2_raddr_ID,
    output logic [4:0]  rd_waddr_ID,
    output logic        ALU_src_ID,
    output logic [3:0]  ALU_ctrl_ID,
    output logic        branch_ID,
    output logic        MemWrite_ID,
    output logic        jal_ID,
    output logic        jalr_ID,
    output logic [1:0]  PMAItoReg_ID,
    output logic        rd_wen_ID
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        w_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr <= P_NOP_INSTR;
            r_pc    <= P_RESET_PC;
        end else if (flush_ID) begin
            r_instr <= P_NOP_INSTR;
        end else if (!w_stall) begin
            r_instr <= instr_IF;
            r_pc    <= PC_IF;
        end
    end

    logic [6:0] w_opcode;
    logic [4:0] w_rd, w_rs1, w_rs2;
    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];

    logic      w_alu_src, w_memw, w_branch, w_jal, w_jalr, w_has_rd;
    logic      w_rs1_used, w_rs2_used;
    logic [1:0] w_pma;
    alu_ctrl_e w_alu_ctrl;
    imm_type_e w_imm_type;

    always_comb begin
        w_alu_src  = 1'b0;
        w_alu_ctrl = ALU_ADD;
        w_pma      = PMA_ALU;
        w_memw     = 1'b0;
        w_branch   = 1'b0;
        w_jal      = 1'b0;
        w_jalr     = 1'b0;
        w_has_rd   = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_imm_type = IMM_R;
        case (w_opcode)
            OPC_OP: begin
                w_has_rd = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                w_alu_ctrl = alu_decode(r_instr[14:12], r_instr[30], 1'b1);
            end
            OPC_OPIMM: begin
                w_has_rd = 1'b1; w_rs1_used = 1'b1; w_alu_src = 1'b1; w_imm_type = IMM_I;
                w_alu_ctrl = alu_decode(r_instr[14:12], r_instr[30], 1'b0);
            end
            OPC_LOAD: begin
                w_has_rd = 1'b1; w_rs1_used = 1'b1; w_alu_src = 1'b1; w_imm_type = IMM_I;
                w_pma = PMA_LOAD;
            end
            OPC_STORE: begin
                w_memw = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1; w_alu_src = 1'b1;
                w_imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                w_branch = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1; w_imm_type = IMM_B;
                w_alu_ctrl = ALU_SUB;
            end
            OPC_JAL: begin
                w_jal = 1'b1; w_has_rd = 1'b1; w_alu_src = 1'b1; w_imm_type = IMM_J; w_pma = PMA_PC4;
            end
            OPC_JALR: begin
                w_jalr = 1'b1; w_has_rd = 1'b1; w_rs1_used = 1'b1; w_alu_src = 1'b1;
                w_imm_type = IMM_I; w_pma = PMA_PC4;
            end
            OPC_LUI: begin
                w_has_rd = 1'b1; w_alu_src = 1'b1; w_imm_type = IMM_U; w_pma = PMA_IMM;
            end
            OPC_AUIPC: begin
                w_has_rd = 1'b1; w_alu_src = 1'b1; w_imm_type = IMM_U; w_alu_ctrl = ALU_ADD_PC;
            end
            default: ;
        endcase
    end

    // Only an in-flight load is unresolvable by EX forwarding.
    logic w_load_use;
    assign w_load_use = rd_wen_EX && (PMAItoReg_EX == PMA_LOAD) && (rd_waddr_EX != 5'd0)
                      && ((w_rs1_used && (w_rs1 == rd_waddr_EX))
                       || (w_rs2_used && (w_rs2 == rd_waddr_EX)));

`ifdef RF_WB_BYPASS_EN
    assign w_stall = w_load_use;
`else
    logic w_wb_col;
    assign w_wb_col = rd_wen_WB && (rd_waddr_WB != 5'd0)
                    && ((w_rs1_used && (w_rs1 == rd_waddr_WB))
                     || (w_rs2_used && (w_rs2 == rd_waddr_WB)));
    assign w_stall = w_load_use || w_wb_col;
`endif

    reg_file u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wen    (rd_wen_WB),
        .i_waddr  (rd_waddr_WB),
        .i_wdata  (rd_wdata_WB),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (rs1_rdata_ID),
        .o_rdata2 (rs2_rdata_ID)
    );

    assign stall_IF     = w_stall;
    assign instr_ID     = r_instr;
    assign PC_ID        = r_pc;
    assign imm_ID       = gen_imm(r_instr, w_imm_type);
    assign rs1_raddr_ID = w_rs1;
    assign rs2_raddr_ID = w_rs2;
    assign rd_waddr_ID  = w_rd;
    assign ALU_src_ID   = w_alu_src;
    assign ALU_ctrl_ID  = w_alu_ctrl;
    assign PMAItoReg_ID = w_pma;
    assign rd_wen_ID    = w_has_rd && (w_rd != 5'd0) && !w_stall;
    assign MemWrite_ID  = w_memw && !w_stall;
    assign branch_ID    = w_branch && !w_stall;
    assign jal_ID       = w_jal && !w_stall;
    assign jalr_ID      = w_jalr && !w_stall;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus queues expected values, a negedge monitor checks them.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_IF, PC_IF;
    logic        flush_ID, rd_wen_EX, rd_wen_WB;
    logic [4:0]  rd_waddr_EX, rd_waddr_WB;
    logic [1:0]  PMAItoReg_EX;
    logic [31:0] rd_wdata_WB;
    logic        stall_IF, ALU_src_ID, branch_ID, MemWrite_ID, jal_ID, jalr_ID, rd_wen_ID;
    logic [31:0] instr_ID, PC_ID, imm_ID, rs1_rdata_ID, rs2_rdata_ID;
    logic [4:0]  rs1_raddr_ID, rs2_raddr_ID, rd_waddr_ID;
    logic [3:0]  ALU_ctrl_ID;
    logic [1:0]  PMAItoReg_ID;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_IF(instr_IF), .PC_IF(PC_IF), .flush_ID(flush_ID),
        .rd_wen_EX(rd_wen_EX), .rd_waddr_EX(rd_waddr_EX), .PMAItoReg_EX(PMAItoReg_EX),
        .rd_wen_WB(rd_wen_WB), .rd_waddr_WB(rd_waddr_WB), .rd_wdata_WB(rd_wdata_WB),
        .stall_IF(stall_IF), .instr_ID(instr_ID), .PC_ID(PC_ID), .imm_ID(imm_ID),
        .rs1_rdata_ID(rs1_rdata_ID), .rs2_rdata_ID(rs2_rdata_ID),
        .rs1_raddr_ID(rs1_raddr_ID), .rs2_raddr_ID(rs2_raddr_ID), .rd_waddr_ID(rd_waddr_ID),
        .ALU_src_ID(ALU_src_ID), .ALU_ctrl_ID(ALU_ctrl_ID), .branch_ID(branch_ID),
        .MemWrite_ID(MemWrite_ID), .jal_ID(jal_ID), .jalr_ID(jalr_ID),
        .PMAItoReg_ID(PMAItoReg_ID), .rd_wen_ID(rd_wen_ID)
    );

    typedef enum int {F_INSTR, F_PC, F_IMM, F_RS1D, F_RS2D, F_RD, F_RDWEN, F_STALL,
                      F_ALUSRC, F_ALUCTRL, F_PMA, F_MEMW, F_BR, F_JAL} fld_e;
    typedef struct {
        int          cyc;
        string       name;
        fld_e        fld;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_field(input fld_e f);
        case (f)
            F_INSTR:   return instr_ID;
            F_PC:      return PC_ID;
            F_IMM:     return imm_ID;
            F_RS1D:    return rs1_rdata_ID;
            F_RS2D:    return rs2_rdata_ID;
            F_RD:      return {27'h0, rd_waddr_ID};
            F_RDWEN:   return {31'h0, rd_wen_ID};
            F_STALL:   return {31'h0, stall_IF};
            F_ALUSRC:  return {31'h0, ALU_src_ID};
            F_ALUCTRL: return {28'h0, ALU_ctrl_ID};
            F_PMA:     return {30'h0, PMAItoReg_ID};
            F_MEMW:    return {31'h0, MemWrite_ID};
            F_BR:      return {31'h0, branch_ID};
            default:   return {31'h0, jal_ID};
        endcase
    endfunction

    function automatic void exp_push(input string nm, input fld_e f, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.fld = f; e.val = v;
        sb.push_back(e);
    endfunction

    // Monitor: every expectation queued for this cycle is checked mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = get_field(e.fld);
            n_tests++;
            if (e.cyc != cyc || act !== e.val) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, act, e.val);
            end else begin
                $display("[TB] ok %s cyc=%0d val=%h", e.name, cyc, act);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_IF = 32'h0000_0013; flush_ID = 1'b0;
        rd_wen_EX = 1'b0; rd_waddr_EX = 5'd0; PMAItoReg_EX = 2'b00;
        rd_wen_WB = 1'b0; rd_waddr_WB = 5'd0; rd_wdata_WB = 32'h0;
    endtask

    task automatic ex_load(input logic [4:0] rd);
        rd_wen_EX = 1'b1; rd_waddr_EX = rd; PMAItoReg_EX = 2'b01;
    endtask

    localparam logic [31:0] ADD_6_5_7  = {7'b0000000, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] SUB_8_5_7  = {7'b0100000, 5'd7, 5'd5, 3'b000, 5'd8, 7'b0110011};
    localparam logic [31:0] ADD_6_0_7  = {7'b0000000, 5'd7, 5'd0, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] ADDI_9_1_5 = {12'd5, 5'd1, 3'b000, 5'd9, 7'b0010011};
    localparam logic [31:0] ADDI_5_0_5 = {12'd5, 5'd0, 3'b000, 5'd5, 7'b0010011};
    localparam logic [31:0] ADD_10_3_0 = {7'b0000000, 5'd0, 5'd3, 3'b000, 5'd10, 7'b0110011};
    localparam logic [31:0] ADD_11_0_0 = {7'b0000000, 5'd0, 5'd0, 3'b000, 5'd11, 7'b0110011};
    localparam logic [31:0] SW_7_8_5   = {7'b0000000, 5'd7, 5'd5, 3'b010, 5'd8, 7'b0100011};
    localparam logic [31:0] BEQ_M4     = {1'b1, 6'b111111, 5'd7, 5'd5, 3'b000, 4'b1110, 1'b1, 7'b1100011};
    localparam logic [31:0] JAL_800    = {1'b0, 10'b0, 1'b1, 8'b0, 5'd1, 7'b1101111};
    localparam logic [31:0] LUI_12345  = {20'h12345, 5'd2, 7'b0110111};
    localparam logic [31:0] AUIPC_1    = {20'h00001, 5'd3, 7'b0010111};

    initial begin
        logic [4:0] a;
        rst_n = 1'b0; PC_IF = 32'h0; idle();
        instr_IF = 32'hFFF0_8093;
        step(); step();
        exp_push("rst_instr", F_INSTR, 32'h13);
        exp_push("rst_pc", F_PC, 32'h0);
        exp_push("rst_rdwen", F_RDWEN, 32'h0);
        exp_push("rst_stall", F_STALL, 32'h0);

        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            a = i[4:0];
            instr_IF = {7'b0, a, a, 3'b000, 5'd0, 7'b0110011};
            PC_IF = i * 4;
            step();
            exp_push("rf_rst_rs1", F_RS1D, 32'h0);
            if (i == 1) exp_push("pc_load", F_PC, 32'h4);
        end

        instr_IF = 32'hFFF0_8093; PC_IF = 32'h100;
        step();
        exp_push("addi_imm", F_IMM, 32'hFFFF_FFFF);
        exp_push("addi_alusrc", F_ALUSRC, 32'h1);
        exp_push("addi_rd", F_RD, 32'h1);
        exp_push("addi_rdwen", F_RDWEN, 32'h1);
        exp_push("addi_pc", F_PC, 32'h100);

        idle(); rd_wen_WB = 1'b1; rd_waddr_WB = 5'd5; rd_wdata_WB = 32'h55;
        step();
        rd_waddr_WB = 5'd7; rd_wdata_WB = 32'h77;
        step();
        idle();

        // Load-use on rs1 holds the add for one cycle.
        instr_IF = ADD_6_5_7;
        step();
        ex_load(5'd5); instr_IF = SUB_8_5_7;
        exp_push("lu_stall", F_STALL, 32'h1);
        exp_push("lu_rdwen", F_RDWEN, 32'h0);
        exp_push("lu_rs1d", F_RS1D, 32'h55);
        exp_push("lu_rs2d", F_RS2D, 32'h77);
        step();
        rd_wen_EX = 1'b0;
        exp_push("lu_hold", F_INSTR, ADD_6_5_7);
        exp_push("lu_release", F_STALL, 32'h0);
        exp_push("lu_rd", F_RD, 32'h6);
        exp_push("lu_rdwen_back", F_RDWEN, 32'h1);
        step();
        exp_push("lu_next", F_INSTR, SUB_8_5_7);
        exp_push("sub_ctrl", F_ALUCTRL, 32'h1);

        // No stall: load to x0, rs2 field unused, rs1=x0, non-load EX writer.
        instr_IF = ADD_6_0_7;
        step();
        ex_load(5'd0);
        exp_push("lu_x0", F_STALL, 32'h0);
        instr_IF = ADDI_9_1_5; ex_load(5'd5);
        step();
        exp_push("lu_rs2_unused", F_STALL, 32'h0);
        exp_push("addi5_imm", F_IMM, 32'h5);
        instr_IF = ADDI_5_0_5;
        step();
        exp_push("lu_rd_only", F_STALL, 32'h0);
        instr_IF = ADD_6_5_7;
        step();
        PMAItoReg_EX = 2'b00;
        exp_push("ex_alu_nostall", F_STALL, 32'h0);
        idle();

        // Flush overrides a concurrent load-use stall.
        instr_IF = ADD_6_5_7;
        step();
        ex_load(5'd5); flush_ID = 1'b1;
        exp_push("fl_stall", F_STALL, 32'h1);
        step();
        idle();
        exp_push("fl_nop", F_INSTR, 32'h13);
        exp_push("fl_stall_clr", F_STALL, 32'h0);

        // Reset during a stall.
        instr_IF = ADD_6_5_7;
        step();
        ex_load(5'd5);
        exp_push("rs_stall", F_STALL, 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_push("rs_nop", F_INSTR, 32'h13);
        exp_push("rs_stall_clr", F_STALL, 32'h0);
        exp_push("rs_pc", F_PC, 32'h0);
        idle();

        // WB collision on x3.
        instr_IF = ADD_10_3_0;
        step();
        rd_wen_WB = 1'b1; rd_waddr_WB = 5'd3; rd_wdata_WB = 32'hDEAD_BEEF;
        exp_push("r_imm0", F_IMM, 32'h0);
`ifdef RF_WB_BYPASS_EN
        exp_push("wb_byp_rs1d", F_RS1D, 32'hDEAD_BEEF);
        exp_push("wb_byp_stall", F_STALL, 32'h0);
`else
        exp_push("wb_col_stall", F_STALL, 32'h1);
        exp_push("wb_col_old", F_RS1D, 32'h0);
`endif
        step();
        rd_wen_WB = 1'b0;
        exp_push("wb_landed", F_RS1D, 32'hDEAD_BEEF);
        exp_push("wb_stall_clr", F_STALL, 32'h0);
        exp_push("wb_instr", F_INSTR, ADD_10_3_0);

        // Writes to x0 are dropped.
        instr_IF = ADD_11_0_0;
        step();
        rd_wen_WB = 1'b1; rd_waddr_WB = 5'd0; rd_wdata_WB = 32'hFFFF_FFFF;
        exp_push("x0_same", F_RS1D, 32'h0);
        exp_push("x0_nostall", F_STALL, 32'h0);
        step();
        rd_wen_WB = 1'b0;
        exp_push("x0_after", F_RS1D, 32'h0);

        instr_IF = SW_7_8_5;
        step();
        exp_push("sw_imm", F_IMM, 32'h8);
        exp_push("sw_memw", F_MEMW, 32'h1);
        exp_push("sw_rdwen", F_RDWEN, 32'h0);
        instr_IF = BEQ_M4;
        step();
        exp_push("beq_imm", F_IMM, 32'hFFFF_FFFC);
        exp_push("beq_br", F_BR, 32'h1);
        exp_push("beq_rdwen", F_RDWEN, 32'h0);
        instr_IF = JAL_800;
        step();
        exp_push("jal_imm", F_IMM, 32'h800);
        exp_push("jal_flag", F_JAL, 32'h1);
        exp_push("jal_pma", F_PMA, 32'h2);
        exp_push("jal_rdwen", F_RDWEN, 32'h1);
        instr_IF = LUI_12345;
        step();
        exp_push("lui_imm", F_IMM, 32'h1234_5000);
        exp_push("lui_pma", F_PMA, 32'h3);
        instr_IF = AUIPC_1;
        step();
        exp_push("auipc_imm", F_IMM, 32'h1000);
        exp_push("auipc_ctrl", F_ALUCTRL, 32'hA);
        instr_IF = 32'hFFFF_FFFF;
        step();
        exp_push("unk_rdwen", F_RDWEN, 32'h0);
        exp_push("unk_memw", F_MEMW, 32'h0);
        exp_push("unk_br", F_BR, 32'h0);
        idle();

        step(); step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain left=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
